// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and sizing for the register-file writeback arbiter.
package regfile_pkg;
  localparam int DATA_W   = 128;
  localparam int ADDR_W   = 4;
  localparam int NUM_REGS = 15;
  localparam logic [ADDR_W-1:0] REG_INVALID = 4'hF;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  typedef enum logic {GNT_ALU = 1'b0, GNT_LSU = 1'b1} gnt_e;

  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return a != REG_INVALID;
  endfunction
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback, reservation and register-file write-port bundle.
interface regfile_wb_if #(
  parameter int DATA_W   = regfile_pkg::DATA_W,
  parameter int ADDR_W   = regfile_pkg::ADDR_W,
  parameter int NUM_REGS = regfile_pkg::NUM_REGS
);
  logic              alu_valid, alu_ready;
  logic [ADDR_W-1:0] alu_addr;
  logic [DATA_W-1:0] alu_data;
  logic              lsu_valid, lsu_ready;
  logic [ADDR_W-1:0] lsu_addr;
  logic [DATA_W-1:0] lsu_data;
  logic              rsv_valid, rsv_ready;
  logic [ADDR_W-1:0] rsv_addr;
  logic                we3;
  logic [ADDR_W-1:0]   ra3;
  logic [DATA_W-1:0]   wd3;
  logic [NUM_REGS-1:0] busy;
  logic                err_addr;

  modport master (
    output alu_valid, alu_addr, alu_data, lsu_valid, lsu_addr, lsu_data,
           rsv_valid, rsv_addr,
    input  alu_ready, lsu_ready, rsv_ready, we3, ra3, wd3, busy, err_addr
  );
  modport slave (
    input  alu_valid, alu_addr, alu_data, lsu_valid, lsu_addr, lsu_data,
           rsv_valid, rsv_addr,
    output alu_ready, lsu_ready, rsv_ready, we3, ra3, wd3, busy, err_addr
  );
endinterface

// File: rtl/regfile_wb_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter; grant is one-hot, pointer moves only on a grant.
module rr_arbiter2
  import regfile_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);
  gnt_e r_last;

  // A grant is always a transfer: ready mirrors grant and grant implies request.
  always_comb begin
    o_gnt = 2'b00;
    if (!rst) begin
      if (i_req[0] && (!i_req[1] || r_last == GNT_LSU)) o_gnt = 2'b01;
      else if (i_req[1])                                 o_gnt = 2'b10;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)         r_last <= GNT_LSU;
    else if (|o_gnt) r_last <= o_gnt[1] ? GNT_LSU : GNT_ALU;
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// ALU/LSU writeback arbiter driving one registered register-file write port.
// Define WB_SCOREBOARD_EN to build the per-register WAW reservation scoreboard.
module regfile_wb_arbiter #(
  parameter int DATA_W   = regfile_pkg::DATA_W,
  parameter int ADDR_W   = regfile_pkg::ADDR_W,
  parameter int NUM_REGS = regfile_pkg::NUM_REGS
) (
  input logic         clk,
  input logic         rst,
  regfile_wb_if.slave bus
);
  import regfile_pkg::*;

  wb_req_t             w_alu, w_lsu, w_sel;
  logic [1:0]          w_gnt;
  logic                w_wb_ok, w_wb_bad, w_rsv_ready, w_rsv_bad;
  logic [NUM_REGS-1:0] w_busy;
  logic                r_we3, r_err;
  logic [ADDR_W-1:0]   r_ra3;
  logic [DATA_W-1:0]   r_wd3;

  assign w_alu = '{valid: bus.alu_valid, addr: bus.alu_addr, data: bus.alu_data};
  assign w_lsu = '{valid: bus.lsu_valid, addr: bus.lsu_addr, data: bus.lsu_data};

  rr_arbiter2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .i_req ({w_lsu.valid, w_alu.valid}),
    .o_gnt (w_gnt)
  );

  assign w_sel    = w_gnt[1] ? w_lsu : w_alu;
  assign w_wb_ok  = (|w_gnt) &&  addr_ok(w_sel.addr);
  assign w_wb_bad = (|w_gnt) && !addr_ok(w_sel.addr);

`ifdef WB_SCOREBOARD_EN
  logic [NUM_REGS-1:0] r_busy;
  logic                w_rsv_xfer;

  // Address 15 has no busy bit, so it is never stalled.
  assign w_rsv_ready = !rst && (!addr_ok(bus.rsv_addr) || !r_busy[bus.rsv_addr]);
  assign w_rsv_xfer  = bus.rsv_valid && w_rsv_ready;
  assign w_rsv_bad   = w_rsv_xfer && !addr_ok(bus.rsv_addr);
  assign w_busy      = r_busy;

  // Set is written last so a same-edge reserve of the retiring register wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      if (w_wb_ok) r_busy[w_sel.addr] <= 1'b0;
      if (w_rsv_xfer && addr_ok(bus.rsv_addr)) r_busy[bus.rsv_addr] <= 1'b1;
    end
  end
`else
  logic w_unused_rsv;
  assign w_unused_rsv = ^{bus.rsv_valid, bus.rsv_addr};
  assign w_rsv_ready  = !rst;
  assign w_rsv_bad    = 1'b0;
  assign w_busy       = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_we3 <= 1'b0;
      r_ra3 <= '0;
      r_wd3 <= '0;
      r_err <= 1'b0;
    end else begin
      r_we3 <= w_wb_ok;
      r_err <= w_wb_bad || w_rsv_bad;
      if (w_wb_ok) begin
        r_ra3 <= w_sel.addr;
        r_wd3 <= w_sel.data;
      end
    end
  end

  assign bus.alu_ready = w_gnt[0];
  assign bus.lsu_ready = w_gnt[1];
  assign bus.rsv_ready = w_rsv_ready;
  assign bus.we3       = r_we3;
  assign bus.ra3       = r_ra3;
  assign bus.wd3       = r_wd3;
  assign bus.busy      = w_busy;
  assign bus.err_addr  = r_err;
endmodule
